line_clear: RTL

Board-compaction engine that produces the `aligne` and `perdu` events consumed by the score display. After each piece lock it scans the playfield row memory from bottom to top and removes every full row, one `aligne` pulse per removed row. It shifts the remaining rows down and zero-fills the top. It raises `perdu` when a non-empty row ends up in the top row. It sits between the piece-placement logic (issues `lock`), the board RAM (row-wide read/write port) and the score block (`aligne`, `perdu`, `reset`).

---
 rtl/board_pkg.sv | 29 ++
 rtl/line_clear.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, row constants and the compaction FSM state type.
package board_pkg;

  localparam int WIDTH  = 10;
  localparam int HEIGHT = 20;
  localparam int ROW_AW = 5;

  localparam logic [WIDTH-1:0]  FULL_ROW   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  EMPTY_ROW  = {WIDTH{1'b0}};
  localparam logic [ROW_AW-1:0] BOTTOM_ROW = ROW_AW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EVAL  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4,
    LOST  = 3'd5
  } state_t;

  function automatic logic row_is_full(input logic [WIDTH-1:0] row);
    return row == FULL_ROW;
  endfunction

  function automatic logic row_is_empty(input logic [WIDTH-1:0] row);
    return row == EMPTY_ROW;
  endfunction

endpackage

// File: rtl/line_clear.sv
// Board compaction after each piece lock: removes full rows bottom-up, shifts the rest down.
// Optional LINE_CLEAR_COUNT_EN adds the `lines` output carrying the rows cleared by the last scan.
module line_clear
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lock,
  output logic              busy,
  output logic              done,
  output logic [ROW_AW-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [ROW_AW-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_en,
  output logic              aligne,
  output logic              perdu
`ifdef LINE_CLEAR_COUNT_EN
  ,
  output logic [ROW_AW:0]   lines
`endif
);

  state_t            state_r;
  logic [ROW_AW-1:0] r_r;
  logic [ROW_AW-1:0] w_r;
  logic [ROW_AW:0]   k_r;
  logic              lost_r;

  logic              row_full_s;
  logic              row_empty_s;
  logic [ROW_AW:0]   k_next_s;
  logic              lost_next_s;

  // Row classification and next-count/lost-flag values for the row under evaluation
  always_comb begin
    row_full_s  = row_is_full(rd_data);
    row_empty_s = row_is_empty(rd_data);
    if (row_full_s) begin
      k_next_s    = k_r + (ROW_AW + 1)'(1);
      lost_next_s = lost_r;
    end else begin
      k_next_s    = k_r;
      lost_next_s = lost_r | (!row_empty_s && (w_r == {ROW_AW{1'b0}}));
    end
  end

  // RAM write port: the kept row comes straight from rd_data, so it cannot be registered;
  // gating with reset stops any write in the cycle a reset is requested
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {ROW_AW{1'b0}};
    wr_data = {WIDTH{1'b0}};
    case (state_r)
      EVAL: begin
        if (!row_full_s && (w_r != r_r)) begin
          wr_en   = reset;
          wr_addr = w_r;
          wr_data = rd_data;
        end else begin
          wr_en   = 1'b0;
        end
      end
      CLEAR: begin
        wr_en   = reset;
        wr_addr = w_r;
        wr_data = EMPTY_ROW;
      end
      default: begin
        wr_en   = 1'b0;
      end
    endcase
  end

  // Scan FSM with counters and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      r_r     <= {ROW_AW{1'b0}};
      w_r     <= {ROW_AW{1'b0}};
      k_r     <= {(ROW_AW + 1){1'b0}};
      lost_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aligne  <= 1'b0;
      perdu   <= 1'b0;
      rd_addr <= {ROW_AW{1'b0}};
`ifdef LINE_CLEAR_COUNT_EN
      lines   <= {(ROW_AW + 1){1'b0}};
`endif
    end else begin
      done   <= 1'b0;
      aligne <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lock) begin
            r_r     <= BOTTOM_ROW;
            w_r     <= BOTTOM_ROW;
            k_r     <= {(ROW_AW + 1){1'b0}};
            lost_r  <= 1'b0;
            rd_addr <= BOTTOM_ROW;
            busy    <= 1'b1;
            state_r <= READ;
          end
        end
        READ: state_r <= EVAL;
        EVAL: begin
          k_r    <= k_next_s;
          lost_r <= lost_next_s;
          if (row_full_s) begin
            aligne <= 1'b1;
          end else begin
            w_r <= w_r - ROW_AW'(1);
          end
          if (r_r == {ROW_AW{1'b0}}) begin
            if (k_next_s != {(ROW_AW + 1){1'b0}}) begin
              state_r <= CLEAR;
            end else begin
              done    <= 1'b1;
              perdu   <= lost_next_s;
              state_r <= DONE;
            end
          end else begin
            r_r     <= r_r - ROW_AW'(1);
            rd_addr <= r_r - ROW_AW'(1);
            state_r <= READ;
          end
        end
        // After the scan w sits at k-1, so it walks the zero-fill down to row 0
        CLEAR: begin
          if (w_r == {ROW_AW{1'b0}}) begin
            done    <= 1'b1;
            perdu   <= lost_r;
            state_r <= DONE;
          end else begin
            w_r <= w_r - ROW_AW'(1);
          end
        end
        DONE: begin
          busy <= 1'b0;
`ifdef LINE_CLEAR_COUNT_EN
          lines <= k_r;
`endif
          state_r <= lost_r ? LOST : IDLE;
        end
        LOST: begin
          busy  <= 1'b0;
          perdu <= 1'b1;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
